// File: rtl/key_evt_pkg.sv
// Shared types and helpers for the key event arbiter: event record, source count, source-index codec.
// Pure declarations, no latency or flow control of its own.
// A source index is {release, lane}: presses occupy 0..3, releases 4..7.
package key_evt_pkg;
    localparam int TS_W      = 16;
    localparam int NUM_LANES = 4;
    localparam int NUM_SRC   = 8;
    localparam int SRC_W     = 3;

    typedef struct packed {
        logic            is_rel;
        logic [1:0]      lane;
        logic [TS_W-1:0] ts;
    } key_evt_t;

    function automatic logic [SRC_W-1:0] src_encode(input logic is_rel, input logic [1:0] lane);
        return {is_rel, lane};
    endfunction

    function automatic logic src_is_release(input logic [SRC_W-1:0] src);
        return src[2];
    endfunction

    function automatic logic [1:0] src_lane(input logic [SRC_W-1:0] src);
        return src[1:0];
    endfunction
endpackage

// File: rtl/key_event_arbiter_if.sv
// Bundle of key-listener inputs and event-consumer handshake for the key event arbiter.
// Wires only; slave is the arbiter side, master is the listener/consumer side.
// Backpressure travels on evt_ready from master to slave.
interface key_event_arbiter_if
    import key_evt_pkg::*;
#(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [NUM_LANES-1:0] key_pressed;
    logic [NUM_LANES-1:0] key_released;
    logic                 tick;
    logic                 evt_ready;
    logic                 clr_overrun;
    logic                 evt_valid;
    logic [1:0]           evt_lane;
    logic                 evt_release;
    logic [TS_W-1:0]      evt_time;
    logic [CW-1:0]        fifo_count;
    logic                 overrun;

    modport master (
        output key_pressed, key_released, tick, evt_ready, clr_overrun,
        input  evt_valid, evt_lane, evt_release, evt_time, fifo_count, overrun
    );

    modport slave (
        input  key_pressed, key_released, tick, evt_ready, clr_overrun,
        output evt_valid, evt_lane, evt_release, evt_time, fifo_count, overrun
    );
endinterface

// File: rtl/key_evt_fifo.sv
// Show-ahead FIFO of key events with occupancy count.
// Latency: a push is visible at the head the cycle after the write edge.
// Backpressure: pushes while full and pops while empty are ignored; the head reads 0 when empty.
module key_evt_fifo
    import key_evt_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  key_evt_t      push_dat,
    input  logic          pop,
    output key_evt_t      head_dat,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);
    key_evt_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    // Gate the head so the event fields read 0 out of reset and whenever empty.
    assign head_dat = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/key_event_arbiter.sv
// Timestamps per-lane press/release pulses and round-robins the 8 sources into an event FIFO.
// Latency: pulse at cycle N -> evt_valid at N+2 into an empty FIFO; one push per cycle at most.
// Backpressure: evt_ready pops; a full FIFO holds sources pending. KEY_EVT_LOCKOUT_EN adds press lockout.
module key_event_arbiter
    import key_evt_pkg::*;
#(
    parameter int DEPTH = 8
`ifdef KEY_EVT_LOCKOUT_EN
    ,
    parameter int LOCK_TKS = 2
`endif
) (
    input logic                  clk,
    input logic                  resetn,
    key_event_arbiter_if.slave   bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [TS_W-1:0]      ts_cnt;
    logic [TS_W-1:0]      ts_lat [NUM_SRC];
    logic [NUM_SRC-1:0]   pend;
    logic [NUM_SRC-1:0]   pulse;
    logic [NUM_SRC-1:0]   grant_oh;
    logic [NUM_SRC-1:0]   set_ovr;
    logic [NUM_LANES-1:0] press_ok;
    logic [SRC_W-1:0]     rr_ptr;
    logic [SRC_W-1:0]     grant;
    logic [SRC_W-1:0]     idx;
    logic                 grant_vld;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 ovr_q;
    logic [CW-1:0]        count;
    key_evt_t             push_dat;
    key_evt_t             head_dat;

    assign pulse   = {bus.key_released, bus.key_pressed & press_ok};
    assign set_ovr = pulse & pend & ~grant_oh;

    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        grant_oh  = '0;
        idx       = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = rr_ptr + SRC_W'(k);
            if (!grant_vld && !fifo_full && pend[idx]) begin
                grant_vld = 1'b1;
                grant     = idx;
            end
        end
        if (grant_vld) grant_oh[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ts_cnt <= '0;
            rr_ptr <= '0;
            pend   <= '0;
            ovr_q  <= 1'b0;
            for (int s = 0; s < NUM_SRC; s++) ts_lat[s] <= '0;
        end else begin
            if (bus.tick)  ts_cnt <= ts_cnt + TS_W'(1);
            if (grant_vld) rr_ptr <= grant + SRC_W'(1);
            for (int s = 0; s < NUM_SRC; s++) begin
                // A pulse re-arms a source that is free or leaving this cycle; otherwise it merges.
                if (pulse[s] && (!pend[s] || grant_oh[s])) begin
                    pend[s]   <= 1'b1;
                    ts_lat[s] <= ts_cnt;
                end else if (grant_oh[s]) begin
                    pend[s] <= 1'b0;
                end
            end
            if (|set_ovr)             ovr_q <= 1'b1;
            else if (bus.clr_overrun) ovr_q <= 1'b0;
        end
    end

`ifdef KEY_EVT_LOCKOUT_EN
    localparam int LK_W = $clog2(LOCK_TKS + 1);
    logic [LK_W-1:0] lock_cnt [NUM_LANES];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int l = 0; l < NUM_LANES; l++) lock_cnt[l] <= '0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (grant_vld && grant == src_encode(1'b0, 2'(l)))
                    lock_cnt[l] <= LK_W'(LOCK_TKS);
                else if (bus.tick && lock_cnt[l] != '0)
                    lock_cnt[l] <= lock_cnt[l] - LK_W'(1);
            end
        end
    end

    always_comb begin
        press_ok = '0;
        for (int l = 0; l < NUM_LANES; l++) press_ok[l] = (lock_cnt[l] == '0);
    end
`else
    assign press_ok = '1;
`endif

    assign push_dat = {src_is_release(grant), src_lane(grant), ts_lat[grant]};

    key_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (grant_vld),
        .push_dat (push_dat),
        .pop      (bus.evt_ready),
        .head_dat (head_dat),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (count)
    );

    assign bus.evt_valid   = !fifo_empty;
    assign bus.evt_lane    = head_dat.lane;
    assign bus.evt_release = head_dat.is_rel;
    assign bus.evt_time    = head_dat.ts;
    assign bus.fifo_count  = count;
    assign bus.overrun     = ovr_q;
endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter: latency, round-robin order, full-FIFO pending, overrun, ts wrap, lockout.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
module tb_key_event_arbiter;
    import key_evt_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    key_event_arbiter_if #(.DEPTH(8)) bus ();

    key_event_arbiter #(.DEPTH(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_evt(input string tag, input logic rel, input logic [1:0] lane, input logic [15:0] t);
        chk(tag, 32'({bus.evt_valid, bus.evt_release, bus.evt_lane, bus.evt_time}),
                 32'({1'b1, rel, lane, t}));
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        step();
    endtask

    initial begin
        resetn           = 1'b0;
        bus.key_pressed  = '0;
        bus.key_released = '0;
        bus.tick         = 1'b0;
        bus.evt_ready    = 1'b0;
        bus.clr_overrun  = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(bus.evt_valid), 32'd0);
        chk("rst_count", 32'(bus.fifo_count), 32'd0);
        chk("rst_ovr",   32'(bus.overrun), 32'd0);
        chk("rst_head",  32'({bus.evt_release, bus.evt_lane, bus.evt_time}), 32'd0);
        resetn = 1'b1;
        step();

        // Single press at ts=5, two-cycle latency, popped immediately.
        bus.evt_ready = 1'b1;
        bus.tick      = 1'b1;
        repeat (5) step();
        bus.tick        = 1'b0;
        bus.key_pressed = 4'b0100;
        step();
        bus.key_pressed = '0;
        chk("t1_lat", 32'(bus.evt_valid), 32'd0);
        step();
        chk_evt("t1_evt", 1'b0, 2'd2, 16'd5);
        chk("t1_cnt", 32'(bus.fifo_count), 32'd1);
        step();
        chk("t1_pop", 32'(bus.evt_valid), 32'd0);

        // Four simultaneous presses from rr_ptr=0 come out back to back.
        do_reset();
        bus.key_pressed = 4'b1111;
        step();
        bus.key_pressed = '0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk_evt("t2_evt", 1'b0, 2'(i), 16'd0);
            chk("t2_cnt", 32'(bus.fifo_count), 32'd1);
            step();
        end
        chk("t2_empty", 32'(bus.evt_valid), 32'd0);

        // Twelve events with ready low: 8 stored, 4 pending, no overrun; rr_ptr starts at 4.
        bus.evt_ready    = 1'b0;
        bus.key_pressed  = 4'b1111;
        bus.key_released = 4'b1111;
        bus.tick         = 1'b1;
        step();
        bus.key_pressed  = '0;
        bus.key_released = '0;
        bus.tick         = 1'b0;
        repeat (8) step();
        chk("t3_fill", 32'(bus.fifo_count), 32'd8);
        bus.key_pressed = 4'b1111;
        step();
        bus.key_pressed = '0;
        step();
        step();
        chk("t3_full", 32'(bus.fifo_count), 32'd8);
        chk("t3_ovr", 32'(bus.overrun), 32'd0);
        chk_evt("t3_hold", 1'b1, 2'd0, 16'd0);
        bus.evt_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk_evt("t3_drain", (i < 4), 2'(i % 4), (i < 8) ? 16'd0 : 16'd1);
            step();
        end
        chk("t3_empty", 32'(bus.evt_valid), 32'd0);

        // Lane-1 press merged while blocked by a full FIFO keeps its first ts.
        bus.evt_ready    = 1'b0;
        bus.key_pressed  = 4'b1111;
        bus.key_released = 4'b1111;
        step();
        bus.key_pressed  = '0;
        bus.key_released = '0;
        repeat (8) step();
        bus.tick = 1'b1;
        step();
        step();
        bus.key_pressed = 4'b0010;
        step();
        bus.tick = 1'b0;
        step();
        bus.key_pressed = '0;
        chk("t4_ovr", 32'(bus.overrun), 32'd1);
        chk("t4_cnt", 32'(bus.fifo_count), 32'd8);
        bus.key_pressed = 4'b0010;
        bus.clr_overrun = 1'b1;
        step();
        bus.key_pressed = '0;
        chk("t4_set_wins", 32'(bus.overrun), 32'd1);
        step();
        bus.clr_overrun = 1'b0;
        chk("t4_clr", 32'(bus.overrun), 32'd0);
        bus.evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk_evt("t4_drain", (i < 4), 2'(i % 4), 16'd1);
            step();
        end
        chk_evt("t4_merged", 1'b0, 2'd1, 16'd3);
        step();
        chk("t4_empty", 32'(bus.evt_valid), 32'd0);

        // Reset in the middle of traffic discards queued and pending events.
        bus.evt_ready   = 1'b0;
        bus.key_pressed = 4'b1111;
        step();
        bus.key_pressed = '0;
        step();
        step();
        chk("rst2_pre", 32'(bus.fifo_count), 32'd2);
        resetn = 1'b0;
        #1;
        chk("rst2_cnt", 32'(bus.fifo_count), 32'd0);
        chk("rst2_valid", 32'(bus.evt_valid), 32'd0);
        step();
        resetn = 1'b1;
        step();
        step();
        chk("rst2_pend", 32'(bus.fifo_count), 32'd0);

        // Timestamp wrap: press with tick at ts=FFFF records FFFF, counter lands on 0.
        bus.tick = 1'b1;
        repeat (65535) step();
        bus.key_pressed = 4'b0001;
        step();
        bus.key_pressed = '0;
        bus.tick        = 1'b0;
        bus.evt_ready   = 1'b1;
        step();
        chk_evt("t5_wrap", 1'b0, 2'd0, 16'hFFFF);
        step();
        bus.key_pressed = 4'b0010;
        step();
        bus.key_pressed = '0;
        step();
        chk_evt("t5_zero", 1'b0, 2'd1, 16'd0);
        step();

        // Repeated lane-3 presses spaced by one tick each.
        do_reset();
        bus.key_pressed = 4'b1000;
        step();
        bus.key_pressed = '0;
        step();
        chk_evt("t6_first", 1'b0, 2'd3, 16'd0);
        step();
        bus.tick = 1'b1;
        step();
        bus.tick        = 1'b0;
        bus.key_pressed = 4'b1000;
        step();
        bus.key_pressed = '0;
        step();
`ifdef KEY_EVT_LOCKOUT_EN
        chk("t6_locked", 32'(bus.evt_valid), 32'd0);
`else
        chk_evt("t6_second", 1'b0, 2'd3, 16'd1);
`endif
        step();
        bus.tick = 1'b1;
        step();
        bus.tick        = 1'b0;
        bus.key_pressed = 4'b1000;
        step();
        bus.key_pressed = '0;
        step();
        chk_evt("t6_third", 1'b0, 2'd3, 16'd2);
        step();
        chk("t6_ovr", 32'(bus.overrun), 32'd0);
        chk("t6_empty", 32'(bus.evt_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
